// File: rtl/gpio_input_capture.sv
// GPIO input conditioning: two-flop synchronizer, optional per-bit debounce,
// edge detection and sticky write-1-to-clear interrupt status per bit.
module gpio_input_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_pin,
    input  logic [WIDTH-1:0] gpio_oen,
    input  logic             debounce_en,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] irq_status,
    output logic             interrupt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_prev_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Counters fall back to zero whenever the bit agrees with data_in or the
    // filter is bypassed, so a mode change always starts from a clean count.
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!debounce_en) begin
                data_d[i] = sync2_q[i];
            end else if (sync2_q[i] != data_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    data_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign rise     = data_q & ~data_prev_q & rise_en & ~gpio_oen;
    assign fall     = ~data_q & data_prev_q & fall_en & ~gpio_oen;
    assign status_d = (status_q & ~irq_clear) | rise | fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            data_q      <= '0;
            data_prev_q <= '0;
            status_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= gpio_pin;
            sync2_q     <= sync1_q;
            data_q      <= data_d;
            data_prev_q <= data_q;
            status_q    <= status_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign data_in    = data_q;
    assign irq_status = status_q;
    assign interrupt  = |status_q;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Directed bench for gpio_input_capture: latency, debounce, edge, clear and
// reset behaviour with hand-computed expectations.
module tb_gpio_input_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gpio_pin;
    logic [7:0] gpio_oen;
    logic       debounce_en;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] irq_clear;
    logic [7:0] data_in;
    logic [7:0] irq_status;
    logic       interrupt;

    int assertCount = 0;
    int failCount   = 0;

    gpio_input_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gpio_pin    (gpio_pin),
        .gpio_oen    (gpio_oen),
        .debounce_en (debounce_en),
        .rise_en     (rise_en),
        .fall_en     (fall_en),
        .irq_clear   (irq_clear),
        .data_in     (data_in),
        .irq_status  (irq_status),
        .interrupt   (interrupt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1ns past the last one, so inputs
    // change and outputs are sampled away from the active edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulseClear(input logic [7:0] mask);
        irq_clear = mask;
        applyStimulus(1);
        irq_clear = 8'h00;
    endtask

    initial begin
        rst_n       = 1'b0;
        gpio_pin    = 8'hFF;
        gpio_oen    = 8'h00;
        debounce_en = 1'b0;
        rise_en     = 8'hFF;
        fall_en     = 8'h00;
        irq_clear   = 8'h00;

        // Reset with pins high, then release in bypass mode
        applyStimulus(3);
        checkOutput("rst_data", data_in, 8'h00);
        checkOutput("rst_status", irq_status, 8'h00);
        checkOutput("rst_irq", interrupt, 1'b0);
        rst_n = 1'b1;
        applyStimulus(2);
        checkOutput("rel_data_e2", data_in, 8'h00);
        applyStimulus(1);
        checkOutput("rel_data_e3", data_in, 8'hFF);
        checkOutput("rel_status_e3", irq_status, 8'h00);
        applyStimulus(1);
        checkOutput("rel_status_e4", irq_status, 8'hFF);
        checkOutput("rel_irq_e4", interrupt, 1'b1);
        pulseClear(8'hFF);
        checkOutput("rel_cleared", irq_status, 8'h00);
        checkOutput("rel_irq_cleared", interrupt, 1'b0);

        // Bypass latency on bit 0
        rise_en  = 8'h00;
        gpio_pin = 8'h00;
        applyStimulus(4);
        rise_en  = 8'h01;
        gpio_pin = 8'h01;
        applyStimulus(2);
        checkOutput("byp_data_e2", data_in, 8'h00);
        applyStimulus(1);
        checkOutput("byp_data_e3", data_in, 8'h01);
        checkOutput("byp_status_e3", irq_status, 8'h00);
        applyStimulus(1);
        checkOutput("byp_status_e4", irq_status, 8'h01);
        checkOutput("byp_irq_e4", interrupt, 1'b1);
        pulseClear(8'h01);
        checkOutput("byp_cleared", irq_status, 8'h00);

        // Debounce: 15-cycle glitch on bit 3 is rejected
        gpio_pin = 8'h00;
        applyStimulus(4);
        rise_en     = 8'h08;
        debounce_en = 1'b1;
        gpio_pin    = 8'h08;
        applyStimulus(15);
        gpio_pin = 8'h00;
        applyStimulus(20);
        checkOutput("glitch15_data", data_in, 8'h00);
        checkOutput("glitch15_status", irq_status, 8'h00);

        // Debounce: 16-cycle pulse passes at edge 18
        gpio_pin = 8'h08;
        applyStimulus(16);
        gpio_pin = 8'h00;
        applyStimulus(1);
        checkOutput("pulse16_data_e17", data_in, 8'h00);
        applyStimulus(1);
        checkOutput("pulse16_data_e18", data_in, 8'h08);
        checkOutput("pulse16_status_e18", irq_status, 8'h00);
        applyStimulus(1);
        checkOutput("pulse16_status_e19", irq_status, 8'h08);
        applyStimulus(20);
        checkOutput("pulse16_data_back", data_in, 8'h00);
        pulseClear(8'h08);
        checkOutput("pulse16_cleared", irq_status, 8'h00);

        // Bounce 1,0,1 then steady: count restarts after the last transition
        gpio_pin = 8'h08;
        applyStimulus(1);
        gpio_pin = 8'h00;
        applyStimulus(1);
        gpio_pin = 8'h08;
        applyStimulus(17);
        checkOutput("bounce_data_early", data_in, 8'h00);
        applyStimulus(1);
        checkOutput("bounce_data_rise", data_in, 8'h08);
        applyStimulus(1);
        checkOutput("bounce_status", irq_status, 8'h08);

        // Back to bypass mid-state; pin low, clear bit 3
        debounce_en = 1'b0;
        gpio_pin    = 8'h00;
        applyStimulus(4);
        checkOutput("mode_switch_data", data_in, 8'h00);
        pulseClear(8'h08);

        // Falling edges with bit 3 configured as an output
        rise_en  = 8'h00;
        fall_en  = 8'h0C;
        gpio_oen = 8'h08;
        gpio_pin = 8'h0C;
        applyStimulus(4);
        checkOutput("fall_pre_data", data_in, 8'h0C);
        checkOutput("fall_pre_status", irq_status, 8'h00);
        gpio_pin = 8'h00;
        applyStimulus(3);
        checkOutput("fall_readback", data_in, 8'h00);
        applyStimulus(1);
        checkOutput("fall_status", irq_status, 8'h04);
        pulseClear(8'h04);
        checkOutput("fall_cleared", irq_status, 8'h00);
        gpio_oen = 8'h00;
        applyStimulus(2);
        checkOutput("oen_toggle_status", irq_status, 8'h00);
        fall_en = 8'h00;

        // Clear/set collision on bit 1
        rise_en  = 8'h02;
        gpio_pin = 8'h02;
        applyStimulus(4);
        checkOutput("coll_first_set", irq_status, 8'h02);
        gpio_pin = 8'h00;
        applyStimulus(4);
        checkOutput("coll_sticky", irq_status, 8'h02);
        gpio_pin = 8'h02;
        applyStimulus(3);
        irq_clear = 8'h02;
        applyStimulus(1);
        irq_clear = 8'h00;
        checkOutput("coll_set_wins", irq_status, 8'h02);
        applyStimulus(2);
        pulseClear(8'h02);
        checkOutput("coll_clear_alone", irq_status, 8'h00);
        checkOutput("coll_irq_low", interrupt, 1'b0);

        // Reset mid-debounce at count 10 forces a full recount
        gpio_pin = 8'h00;
        applyStimulus(4);
        rise_en     = 8'h08;
        debounce_en = 1'b1;
        gpio_pin    = 8'h08;
        applyStimulus(12);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_data", data_in, 8'h00);
        checkOutput("midrst_status", irq_status, 8'h00);
        applyStimulus(2);
        rst_n = 1'b1;
        applyStimulus(17);
        checkOutput("midrst_data_e17", data_in, 8'h00);
        applyStimulus(1);
        checkOutput("midrst_data_e18", data_in, 8'h08);
        applyStimulus(1);
        checkOutput("midrst_status_e19", irq_status, 8'h08);
        checkOutput("midrst_irq_e19", interrupt, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/gpio_input_capture.md
# gpio_input_capture

Input-side companion to the per-bit GPIO output driver: conditions the raw pad values of a WIDTH-bit GPIO port for the PicoBlaze. Each bit passes through a two-flop synchronizer and an optional per-bit debounce filter, followed by rising and falling edge detection. Detected edges set sticky, individually clearable interrupt status bits. The block sits between the GPIO pads and the PicoBlaze port-read/interrupt logic.

## Interface
- WIDTH, 8, number of GPIO bits
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before data_in updates; legal range >= 1
- clk  input  1  system clock; all state is on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- gpio_pin  input  WIDTH  raw pad values, asynchronous to clk
- gpio_oen  input  WIDTH  per-bit output enable; 1 = bit is driven as an output, so its edge events are suppressed
- debounce_en  input  1  1 = debounce filter active; 0 = filter bypassed
- rise_en  input  WIDTH  per-bit rising-edge interrupt enable
- fall_en  input  WIDTH  per-bit falling-edge interrupt enable
- irq_clear  input  WIDTH  per-bit single-cycle clear strobe (write-1-to-clear)
- data_in  output  WIDTH  conditioned pin value seen by the CPU
- irq_status  output  WIDTH  sticky per-bit edge status
- interrupt  output  1  OR-reduction of irq_status

## Operation
- **Synchronizer.** Per bit, sync1 <= gpio_pin and sync2 <= sync1. No logic sits between sync1 and sync2.
- **Debounce (debounce_en=1).** Each bit has a counter of width max(1, $clog2(DEBOUNCE_CYCLES)).
  - When sync2 == data_in, the counter is cleared to 0.
  - When sync2 != data_in and count == DEBOUNCE_CYCLES-1: data_in <= sync2 and count <= 0.
  - When sync2 != data_in otherwise: count increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) never reaches data_in.
- **Bypass (debounce_en=0).** data_in <= sync2 every cycle and counters are held at 0. This behaves identically to DEBOUNCE_CYCLES=1.
- **debounce_en changes mid-count.** Counters clear, and the new mode takes effect the next cycle.
- **Edge detect.** data_in_d <= data_in. Per bit:
  - rise = data_in & ~data_in_d & rise_en & ~gpio_oen
  - fall = ~data_in & data_in_d & fall_en & ~gpio_oen
- **Status update.** irq_status[i] <= (irq_status[i] & ~irq_clear[i]) | rise[i] | fall[i].
  - When a set and a clear occur in the same cycle, the set wins.
  - The status bit stays set until it is cleared; further edges have no additional effect.
- **Output-configured bits.** data_in still tracks the pad (readback of the driven value), but no status is set. Toggling gpio_oen itself never creates an event.
- **Enable changes.** Clearing rise_en/fall_en does not clear existing status.
- **interrupt.** Equals |irq_status and is a direct OR of flops with no extra register.
- **Reset.** sync1, sync2, data_in, data_in_d, counters, irq_status and interrupt all go to 0. A pin held high through reset release therefore yields a rising event (if rise_en=1) once it propagates; this is intentional.

## Timing
- Define edge 1 as the first clk edge that samples a new pin value.
- Latency from pin change to data_in change:
  - Debounce on: data_in updates at edge 2+DEBOUNCE_CYCLES (edge 18 at the default).
  - Debounce off: edge 3.
- irq_status and interrupt assert one edge after data_in changes:
  - Debounce on: edge 3+DEBOUNCE_CYCLES.
  - Debounce off: edge 4.
- irq_clear takes effect on the edge that samples it; irq_status and interrupt deassert in the following cycle.
- rst_n assertion clears all state immediately, including a debounce count in progress.
- Reset release is synchronous to clk through the normal flop path; no cycle after release uses stale state.

## Test plan
- **Reset behaviour.** Assert rst_n=0 with gpio_pin=8'hFF. Require all outputs 0 during reset. Release with debounce_en=0 and rise_en=8'hFF: require data_in=8'hFF after 3 edges, and irq_status=8'hFF with interrupt=1 one edge later.
- **Bypass latency.** debounce_en=0, gpio_oen=0, rise_en=8'h01. Toggle gpio_pin[0] 0->1. Require data_in[0]=1 at edge 3 and irq_status=8'h01 at edge 4.
- **Debounce filtering.** DEBOUNCE_CYCLES=16, debounce_en=1.
  - A 15-cycle high pulse on bit 3 -> data_in stays 0 and no status is set.
  - A 16-cycle pulse -> data_in[3] rises at edge 18.
  - Bounce pattern 1,0,1 then steady 1 -> the counter restarts, and data_in rises 16 cycles after the last transition.
- **Falling edges and output bits.** fall_en=8'h0C, gpio_oen=8'h08. Drive bits 2 and 3 from 1 to 0. Require irq_status=8'h04 only, with data_in[3]=0 (readback still works).
- **Clear/set collision.** Bit 1 has status set. Pulse irq_clear[1] on the same edge a new rise on bit 1 is detected -> irq_status[1] stays 1. A later clear alone -> irq_status[1]=0 and interrupt=0 the next cycle.
- **Reset mid-debounce.** Assert rst_n at count 10 of 16 -> data_in=0 and counters=0. After release with the pin still high, require a full 16-cycle count before data_in=1.
